// File: rtl/pong_score_keeper.sv
// Score keeper for the pong game: BCD score pairs, serve hold-off timing,
// win detection and serve pulses back to the ball logic.
module pong_score_keeper #(
  parameter int WIN_SCORE      = 11,
  parameter int HOLDOFF_CYCLES = 25000000,
  parameter int CNT_W          = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       restart,
  output logic [3:0] first_1,
  output logic [3:0] first_0,
  output logic [3:0] second_1,
  output logic [3:0] second_0,
  output logic       serve,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    ST_HOLDOFF   = 2'd0,
    ST_PLAY      = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [3:0]       WIN_TENS = 4'(WIN_SCORE / 10);
  localparam logic [3:0]       WIN_ONES = 4'(WIN_SCORE % 10);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       p1_tens_q, p1_ones_q, p2_tens_q, p2_ones_q;
  logic             serve_q, serve_dir_q, game_over_q;
  logic [1:0]       winner_q;

  logic [3:0]       p1_tens_d, p1_ones_d, p2_tens_d, p2_ones_d;
  logic             p1_wins, p2_wins;

  // Two-digit BCD increment; 99 saturates rather than wrapping.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] r;
    if (ones != 4'd9)      r = {tens, ones + 4'd1};
    else if (tens != 4'd9) r = {tens + 4'd1, 4'd0};
    else                   r = {tens, ones};
    return r;
  endfunction

  always_comb begin
    {p1_tens_d, p1_ones_d} = bcd_inc(p1_tens_q, p1_ones_q);
    {p2_tens_d, p2_ones_d} = bcd_inc(p2_tens_q, p2_ones_q);
    p1_wins = (p1_tens_d == WIN_TENS) && (p1_ones_d == WIN_ONES);
    p2_wins = (p2_tens_d == WIN_TENS) && (p2_ones_d == WIN_ONES);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HOLDOFF;
      cnt_q       <= RELOAD;
      p1_tens_q   <= 4'd0;
      p1_ones_q   <= 4'd0;
      p2_tens_q   <= 4'd0;
      p2_ones_q   <= 4'd0;
      serve_q     <= 1'b0;
      serve_dir_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      serve_q <= 1'b0;
      if (restart) begin
        state_q     <= ST_HOLDOFF;
        cnt_q       <= RELOAD;
        p1_tens_q   <= 4'd0;
        p1_ones_q   <= 4'd0;
        p2_tens_q   <= 4'd0;
        p2_ones_q   <= 4'd0;
        serve_dir_q <= 1'b0;
        game_over_q <= 1'b0;
        winner_q    <= 2'b00;
      end else begin
        case (state_q)
          ST_PLAY: begin
            // Simultaneous points are treated as a replay: no score, new serve.
            if (point_p1 && point_p2) begin
              state_q <= ST_HOLDOFF;
              cnt_q   <= RELOAD;
            end else if (point_p1) begin
              p1_tens_q   <= p1_tens_d;
              p1_ones_q   <= p1_ones_d;
              serve_dir_q <= 1'b1;
              if (p1_wins) begin
                state_q     <= ST_GAME_OVER;
                game_over_q <= 1'b1;
                winner_q    <= 2'b01;
              end else begin
                state_q <= ST_HOLDOFF;
                cnt_q   <= RELOAD;
              end
            end else if (point_p2) begin
              p2_tens_q   <= p2_tens_d;
              p2_ones_q   <= p2_ones_d;
              serve_dir_q <= 1'b0;
              if (p2_wins) begin
                state_q     <= ST_GAME_OVER;
                game_over_q <= 1'b1;
                winner_q    <= 2'b10;
              end else begin
                state_q <= ST_HOLDOFF;
                cnt_q   <= RELOAD;
              end
            end
          end
          ST_HOLDOFF: begin
            if (cnt_q == '0) begin
              state_q <= ST_PLAY;
              serve_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_GAME_OVER: ;
          default: begin
            state_q <= ST_HOLDOFF;
            cnt_q   <= RELOAD;
          end
        endcase
      end
    end
  end

  assign first_1   = p1_tens_q;
  assign first_0   = p1_ones_q;
  assign second_1  = p2_tens_q;
  assign second_0  = p2_ones_q;
  assign serve     = serve_q;
  assign serve_dir = serve_dir_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: table vectors, hand sequences for the game
// corners, and random play checked against an integer-score reference model.
module tb_pong_score_keeper;

  localparam int H   = 4;
  localparam int WIN = 11;
  localparam int CW  = 3;
  localparam int W   = 21;

  logic       clk = 1'b0;
  logic       reset, point_p1, point_p2, restart;
  logic [3:0] first_1, first_0, second_1, second_0;
  logic       serve, serve_dir, game_over;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: plain integer scores and a countdown of edges to serve.
  int m_p1, m_p2, m_timer, m_win;
  bit m_over, m_play, m_serve, m_dir;

  typedef struct {
    bit           p1;
    bit           p2;
    bit           rs;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl[15];

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  pong_score_keeper #(.WIN_SCORE(WIN), .HOLDOFF_CYCLES(H), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .point_p1(point_p1), .point_p2(point_p2),
    .restart(restart), .first_1(first_1), .first_0(first_0),
    .second_1(second_1), .second_0(second_0), .serve(serve),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner)
  );

  function automatic logic [W-1:0] mk(int f1, int f0, int s1, int s0,
                                      bit sv, bit dir, bit go, int win);
    return {4'(f1), 4'(f0), 4'(s1), 4'(s0), sv, dir, go, 2'(win)};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {first_1, first_0, second_1, second_0, serve, serve_dir, game_over, winner};
  endfunction

  function automatic logic [W-1:0] model_vec();
    return mk(m_p1 / 10, m_p1 % 10, m_p2 / 10, m_p2 % 10, m_serve, m_dir, m_over, m_win);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_p1 = 0; m_p2 = 0; m_win = 0; m_over = 0; m_dir = 0;
    m_serve = 0; m_play = 0; m_timer = H;
  endtask

  task automatic m_step(input bit a, input bit b, input bit r);
    if (r) begin
      m_reset();
    end else if (m_over) begin
      m_serve = 0;
    end else if (m_play) begin
      m_serve = 0;
      if (a && b) begin
        m_play = 0; m_timer = H;
      end else if (a || b) begin
        if (a) begin m_p1 = (m_p1 < 99) ? m_p1 + 1 : 99; m_dir = 1; end
        else   begin m_p2 = (m_p2 < 99) ? m_p2 + 1 : 99; m_dir = 0; end
        m_play = 0;
        if ((a ? m_p1 : m_p2) == WIN) begin
          m_over = 1; m_win = a ? 1 : 2;
        end else begin
          m_timer = H;
        end
      end
    end else begin
      m_timer--;
      m_serve = (m_timer == 0);
      if (m_timer == 0) m_play = 1;
    end
  endtask

  // Driver: one clock with the given inputs, then scoreboard compare.
  task automatic step(input bit a, input bit b, input bit r);
    point_p1 = a; point_p2 = b; restart = r;
    @(posedge clk);
    m_step(a, b, r);
    #1;
    exp_q.push_back(model_vec());
    check("scoreboard", 32'(dut_vec()), 32'(exp_q.pop_front()));
    @(negedge clk);
  endtask

  task automatic wait_play();
    for (int i = 0; i < 20 && !m_play; i++) step(0, 0, 0);
    if (!m_play) begin
      checks++; errors++;
      $display("FAIL wait_play: got no serve expected serve within 20 cycles");
    end
  endtask

  task automatic score(input bit a, input bit b);
    wait_play();
    step(a, b, 0);
  endtask

  task automatic serve_latency(input string name, input bit r_first);
    int n;
    n = 0;
    if (r_first) step(0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      n++;
      if (serve === 1'b1) break;
    end
    check(name, n, H);
  endtask

  initial begin
    int serves;
    logic [15:0] digits;

    tbl[0]  = '{0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[4]  = '{1, 0, 0, mk(0, 1, 0, 0, 0, 1, 0, 0)};
    tbl[5]  = '{0, 1, 0, mk(0, 1, 0, 0, 0, 1, 0, 0)};
    tbl[6]  = '{0, 0, 0, mk(0, 1, 0, 0, 0, 1, 0, 0)};
    tbl[7]  = '{0, 0, 0, mk(0, 1, 0, 0, 0, 1, 0, 0)};
    tbl[8]  = '{0, 0, 0, mk(0, 1, 0, 0, 1, 1, 0, 0)};
    tbl[9]  = '{1, 1, 0, mk(0, 1, 0, 0, 0, 1, 0, 0)};
    tbl[10] = '{0, 0, 0, mk(0, 1, 0, 0, 0, 1, 0, 0)};
    tbl[11] = '{0, 0, 0, mk(0, 1, 0, 0, 0, 1, 0, 0)};
    tbl[12] = '{0, 0, 0, mk(0, 1, 0, 0, 0, 1, 0, 0)};
    tbl[13] = '{0, 0, 0, mk(0, 1, 0, 0, 1, 1, 0, 0)};
    tbl[14] = '{0, 1, 0, mk(0, 1, 0, 1, 0, 0, 0, 0)};

    reset = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0; restart = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(dut_vec()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    reset = 1'b1;
    m_reset();

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].p1, tbl[i].p2, tbl[i].rs);
      check($sformatf("table[%0d]", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end

    // Player 2 from 1 to 10: tens carry without disturbing player 1.
    repeat (8) score(0, 1);
    score(0, 1);
    check("p2_carry", {second_1, second_0, first_1, first_0}, 32'h1001);

    // Player 1 from 1 to 11 wins.
    repeat (10) score(1, 0);
    check("p1_win", {game_over, winner, first_1, first_0}, {1'b1, 2'b01, 4'd1, 4'd1});

    serves = 0;
    digits = {first_1, first_0, second_1, second_0};
    repeat (30) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      if (serve === 1'b1) serves++;
    end
    check("over_no_serve", serves, 0);
    check("over_digits_frozen", {first_1, first_0, second_1, second_0}, digits);

    // Restart from GAME_OVER, held for two cycles.
    step(0, 0, 1);
    check("restart_clear", 32'(dut_vec()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    serve_latency("restart_serve_latency", 1'b1);

    // Random play with occasional restarts.
    repeat (1500) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 199) == 0);
    end

    // Asynchronous reset mid hold-off.
    step(0, 0, 1);
    wait_play();
    step(1, 0, 0);
    step(0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 32'(dut_vec()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    serve_latency("reset_serve_latency", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pong_score_keeper.md
Name: pong_score_keeper

Overview:
Produces the four BCD score digits that feed the multiplexed seven-segment driver: player-1 tens/ones and player-2 tens/ones. It accepts one-cycle point pulses from the ball/collision logic and enforces a serve hold-off after each point. It detects the winning score and issues serve pulses back to the ball logic. It runs entirely in the 25 MHz pixel-clock domain.

Parameters:
WIN_SCORE, 11, points needed to win; legal range 1..99.
HOLDOFF_CYCLES, 25000000, post-point / post-restart delay before the next serve (1 s at 25 MHz); must be >= 1.
CNT_W, 25, width of the hold-off counter; must satisfy 2^CNT_W > HOLDOFF_CYCLES.

Ports:
clk  in  1  25 MHz system clock; all logic is on its rising edge.
reset  in  1  asynchronous, active-low reset.
point_p1  in  1  one-cycle pulse: player 1 scored.
point_p2  in  1  one-cycle pulse: player 2 scored.
restart  in  1  synchronous new-game request, level or pulse.
first_1  out  4  player-1 tens digit, BCD.
first_0  out  4  player-1 ones digit, BCD.
second_1  out  4  player-2 tens digit, BCD.
second_0  out  4  player-2 ones digit, BCD.
serve  out  1  one-cycle pulse: the ball logic may launch the ball.
serve_dir  out  1  launch direction: 0 toward player 1, 1 toward player 2.
game_over  out  1  high while in GAME_OVER.
winner  out  2  00 none, 01 player 1, 10 player 2.

Behaviour:
- Reset (reset low, asynchronous):
  - all digits 0, serve 0, serve_dir 0, game_over 0, winner 00.
  - state HOLDOFF with the counter loaded to HOLDOFF_CYCLES-1, so the first serve occurs after the full delay.
- States:
  - PLAY: point inputs are sampled.
  - HOLDOFF: point inputs are ignored; the counter decrements each cycle.
  - GAME_OVER: point inputs are ignored.
- Priority: restart > point events > counter expiry.
- restart high, any state:
  - next edge clears all digits, winner=00, game_over=0, serve_dir=0.
  - enters HOLDOFF with a full reload.
  - while restart stays high, the block stays in HOLDOFF with the counter held at reload.
- PLAY, exactly one of point_p1/point_p2 high:
  - the scorer's BCD pair increments on that edge and is visible the next cycle.
  - Ones digit 9 -> 0 with a tens carry. Pair 99 saturates; it is unreachable when WIN_SCORE <= 99.
  - serve_dir := the scorer's opponent's direction: point_p1 -> 1, point_p2 -> 0.
  - If the new value == WIN_SCORE: go to GAME_OVER, game_over=1, winner = scorer (01/10). The comparison uses the BCD constants WIN_SCORE/10 and WIN_SCORE%10.
  - Otherwise: go to HOLDOFF with a full reload.
- PLAY, both points high in the same cycle:
  - no digit changes and serve_dir is unchanged.
  - go to HOLDOFF with a full reload (replayed point).
- HOLDOFF:
  - counter decrements each cycle.
  - in the cycle the counter is 0, the next edge enters PLAY and asserts serve for exactly that one following cycle.
  - total serve latency after the scoring edge = HOLDOFF_CYCLES cycles.
- serve:
  - never high in GAME_OVER or HOLDOFF except the single exit pulse.
  - never high in two consecutive cycles.
- Point pulses arriving in HOLDOFF or GAME_OVER are dropped with no effect and are not queued.
- Digits are always valid BCD (0..9); they never show an intermediate value.
- Reset asserted mid-hold-off or mid-game returns immediately to the reset values above.

Test Plan:
- HOLDOFF_CYCLES=4: release reset -> serve pulses once, 4 cycles after the first clk edge with reset high; serve_dir=0; digits 0000.
- In PLAY, point_p1 pulse -> next cycle first_0=1; serve_dir=1; serve appears 4 cycles later; a point_p2 pulse injected during the hold-off leaves second_0=0.
- Drive player 2 from 9 to 10 points -> second_1=1, second_0=0 with no other digit changed.
- WIN_SCORE=11, player 1 reaches 11 -> first_1=1, first_0=1, game_over=1, winner=01; further point pulses are ignored; serve stays 0 indefinitely.
- point_p1 and point_p2 high in the same PLAY cycle -> digits unchanged, serve_dir unchanged, serve 4 cycles later.
- restart while in GAME_OVER -> next cycle digits 0000, winner=00, game_over=0, serve 4 cycles after restart deasserts; assert reset mid-hold-off -> outputs clear asynchronously before the next edge.
